// File: rtl/useq_pkg.sv
// Shared types and constants for the microprogram sequencer: FSM states,
// dispatch-table entry layout and the default opcode map.
package useq_pkg;

  localparam int USEQ_OPC_W      = 6;
  localparam int USEQ_UPC_W      = 6;
  localparam int USEQ_LEN_W      = 3;
  localparam int USEQ_FETCH_BASE = 1;
  localparam int USEQ_FETCH_LEN  = 3;
  localparam int USEQ_HALT_OPC   = 57;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } useq_state_t;

  typedef struct packed {
    logic [USEQ_UPC_W-1:0] base;
    logic [USEQ_LEN_W-1:0] len;
    logic                  cond;
    logic [USEQ_UPC_W-1:0] alt_base;
    logic [USEQ_LEN_W-1:0] alt_len;
  } dispatch_entry_t;

  // A zero length marks an opcode with no microcode (illegal-opcode trap).
  function automatic dispatch_entry_t default_entry(input int unsigned opc);
    dispatch_entry_t e;
    e = '0;
    case (opc)
      4:  begin e.base = USEQ_UPC_W'(4);  e.len = USEQ_LEN_W'(4); end
      8:  begin e.base = USEQ_UPC_W'(8);  e.len = USEQ_LEN_W'(4); end
      12: begin e.base = USEQ_UPC_W'(12); e.len = USEQ_LEN_W'(2); end
      36: begin e.base = USEQ_UPC_W'(36); e.len = USEQ_LEN_W'(1); end
      52: begin
        e.base     = USEQ_UPC_W'(52);
        e.len      = USEQ_LEN_W'(2);
        e.cond     = 1'b1;
        e.alt_base = USEQ_UPC_W'(54);
        e.alt_len  = USEQ_LEN_W'(1);
      end
      56: begin e.base = USEQ_UPC_W'(56); e.len = USEQ_LEN_W'(1); end
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/useq_if.sv
// Control-side bus of the microprogram sequencer; master drives the IR/ALU
// inputs, slave is the sequencer itself.
interface useq_if
  import useq_pkg::*;
#(
  parameter int OPC_W = USEQ_OPC_W,
  parameter int UPC_W = USEQ_UPC_W
) ();

  logic             i_start;
  logic             i_stall;
  logic [OPC_W-1:0] i_ir_opcode;
  logic             i_z_flag;
  logic [UPC_W-1:0] o_upc;
  logic             o_upc_valid;
  logic             o_instr_done;
  logic             o_busy;
  logic             o_halted;
  logic             o_illegal;

  modport master (
    output i_start, i_stall, i_ir_opcode, i_z_flag,
    input  o_upc, o_upc_valid, o_instr_done, o_busy, o_halted, o_illegal
  );

  modport slave (
    input  i_start, i_stall, i_ir_opcode, i_z_flag,
    output o_upc, o_upc_valid, o_instr_done, o_busy, o_halted, o_illegal
  );

endinterface

// File: rtl/useq_dispatch_rom.sv
// Combinational opcode -> dispatch entry lookup over all 2**OPC_W opcodes.
module useq_dispatch_rom
  import useq_pkg::*;
#(
  parameter int OPC_W = USEQ_OPC_W,
  parameter int UPC_W = USEQ_UPC_W,
  parameter int LEN_W = USEQ_LEN_W
) (
  input  logic [OPC_W-1:0] i_opcode,
  output logic [UPC_W-1:0] o_base,
  output logic [LEN_W-1:0] o_len,
  output logic             o_cond,
  output logic [UPC_W-1:0] o_alt_base,
  output logic [LEN_W-1:0] o_alt_len
);

  dispatch_entry_t w_entry;

  always_comb begin
    w_entry    = default_entry(32'(i_opcode));
    o_base     = UPC_W'(w_entry.base);
    o_len      = LEN_W'(w_entry.len);
    o_cond     = w_entry.cond;
    o_alt_base = UPC_W'(w_entry.alt_base);
    o_alt_len  = LEN_W'(w_entry.alt_len);
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: FETCH micro-sequence, opcode dispatch (with JPNZ
// alternate entry), EXEC micro-sequence, HALT park and sticky illegal trap.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int OPC_W      = USEQ_OPC_W,
  parameter int UPC_W      = USEQ_UPC_W,
  parameter int LEN_W      = USEQ_LEN_W,
  parameter int FETCH_BASE = USEQ_FETCH_BASE,
  parameter int FETCH_LEN  = USEQ_FETCH_LEN,
  parameter int HALT_OPC   = USEQ_HALT_OPC
) (
  input logic   clk,
  input logic   rst,
  useq_if.slave bus
);

  localparam int STEP_W = (LEN_W > $clog2(FETCH_LEN)) ? LEN_W : $clog2(FETCH_LEN);

  useq_state_t       r_state;
  logic [STEP_W-1:0] r_step;
  logic [UPC_W-1:0]  r_upc;
  logic [UPC_W-1:0]  r_base;
  logic [LEN_W-1:0]  r_len;
  logic              r_valid;
  logic              r_last;
  logic              r_illegal;

  logic [UPC_W-1:0]  w_base;
  logic [LEN_W-1:0]  w_len;
  logic              w_cond;
  logic [UPC_W-1:0]  w_alt_base;
  logic [LEN_W-1:0]  w_alt_len;
  logic              w_take_alt;
  logic [UPC_W-1:0]  w_sel_base;
  logic [LEN_W-1:0]  w_sel_len;
  logic [STEP_W-1:0] w_step_inc;

  useq_dispatch_rom #(
    .OPC_W (OPC_W),
    .UPC_W (UPC_W),
    .LEN_W (LEN_W)
  ) u_rom (
    .i_opcode   (bus.i_ir_opcode),
    .o_base     (w_base),
    .o_len      (w_len),
    .o_cond     (w_cond),
    .o_alt_base (w_alt_base),
    .o_alt_len  (w_alt_len)
  );

  assign w_take_alt = w_cond && !bus.i_z_flag;
  assign w_sel_base = w_take_alt ? w_alt_base : w_base;
  assign w_sel_len  = w_take_alt ? w_alt_len  : w_len;
  assign w_step_inc = r_step + STEP_W'(1);

  // r_last flags that the displayed upc is the final EXEC step of the opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_step    <= '0;
      r_upc     <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state <= ST_FETCH;
            r_step  <= '0;
            r_upc   <= UPC_W'(FETCH_BASE);
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (!bus.i_stall) begin
            if (r_step == STEP_W'(FETCH_LEN - 1)) begin
              if (bus.i_ir_opcode == OPC_W'(HALT_OPC)) begin
                r_state <= ST_HALT;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
              end else if (w_sel_len == '0) begin
                r_illegal <= 1'b1;
                r_step    <= '0;
                r_upc     <= UPC_W'(FETCH_BASE);
              end else begin
                r_state <= ST_EXEC;
                r_step  <= '0;
                r_upc   <= w_sel_base;
                r_base  <= w_sel_base;
                r_len   <= w_sel_len;
                r_last  <= (w_sel_len == LEN_W'(1));
              end
            end else begin
              r_step <= w_step_inc;
              r_upc  <= UPC_W'(FETCH_BASE) + UPC_W'(w_step_inc);
            end
          end
        end
        ST_EXEC: begin
          if (!bus.i_stall) begin
            if (r_last) begin
              r_state <= ST_FETCH;
              r_step  <= '0;
              r_upc   <= UPC_W'(FETCH_BASE);
              r_last  <= 1'b0;
            end else begin
              r_step <= w_step_inc;
              r_upc  <= r_base + UPC_W'(w_step_inc);
              r_last <= (w_step_inc == (STEP_W'(r_len) - STEP_W'(1)));
            end
          end
        end
        ST_HALT: begin
          r_valid <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_upc        = r_upc;
  assign bus.o_upc_valid  = r_valid;
  assign bus.o_instr_done = r_last && (r_state == ST_EXEC) && !bus.i_stall;
  assign bus.o_busy       = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign bus.o_halted     = (r_state == ST_HALT);
  assign bus.o_illegal    = r_illegal;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus randomized
// opcode/stall traffic against a per-instruction address-list reference model.
module tb_micro_sequencer;
  import useq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic modelIllegal = 1'b0;

  always #5 clk = ~clk;

  useq_if bus ();

  micro_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic stall);
    bus.i_start = start;
    bus.i_stall = stall;
  endtask

  // Opcode map as documented for the control unit: base/length, JPNZ alternate on z=0.
  task automatic refEntry(input int opc, input logic z, output int base, output int len);
    base = 0;
    len  = 0;
    case (opc)
      4:  begin base = 4;  len = 4; end
      8:  begin base = 8;  len = 4; end
      12: begin base = 12; len = 2; end
      36: begin base = 36; len = 1; end
      52: begin
        if (!z) begin base = 54; len = 1; end
        else    begin base = 52; len = 2; end
      end
      56: begin base = 56; len = 1; end
      default: begin base = 0; len = 0; end
    endcase
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("rst_upc", 32'(bus.o_upc), 0);
    checkOutput("rst_valid", 32'(bus.o_upc_valid), 0);
    checkOutput("rst_done", 32'(bus.o_instr_done), 0);
    checkOutput("rst_busy", 32'(bus.o_busy), 0);
    checkOutput("rst_halted", 32'(bus.o_halted), 0);
    checkOutput("rst_illegal", 32'(bus.o_illegal), 0);
    rst = 1'b0;
    modelIllegal = 1'b0;
  endtask

  task automatic startSeq();
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
  endtask

  // mode 0: no stall, 1: random stall (max 2 in a row), 2: stall twice at upc=9.
  task automatic runInstr(input int opc, input logic z, input int mode);
    int  q[$];
    int  base, len, lastIdx, held, run;
    bit  isHalt;
    logic stl;
    refEntry(opc, z, base, len);
    isHalt = (opc == 57);
    bus.i_ir_opcode = 6'(opc);
    bus.i_z_flag = z;
    for (int i = 0; i < 3; i++) q.push_back(1 + i);
    if (!isHalt && len > 0)
      for (int i = 0; i < len; i++) q.push_back((base + i) % 64);
    lastIdx = (!isHalt && len > 0) ? q.size() - 1 : -1;
    held = 0;
    run = 0;
    for (int k = 0; k < q.size(); ) begin
      stl = 1'b0;
      if (mode == 1 && run < 2) stl = ($urandom_range(99) < 30);
      if (mode == 2 && q[k] == 9 && held < 2) begin stl = 1'b1; held++; end
      run = stl ? run + 1 : 0;
      applyStimulus(1'($urandom_range(1)), stl);
      #1;
      checkOutput($sformatf("upc_op%0d", opc), 32'(bus.o_upc), q[k]);
      checkOutput("valid", 32'(bus.o_upc_valid), 1);
      checkOutput("busy", 32'(bus.o_busy), 1);
      checkOutput($sformatf("done_op%0d", opc), 32'(bus.o_instr_done), 32'(k == lastIdx && !stl));
      checkOutput("illegal", 32'(bus.o_illegal), 32'(modelIllegal));
      tick();
      if (!stl) k++;
    end
    applyStimulus(1'b0, 1'b0);
    if (isHalt) begin
      checkOutput("halt_halted", 32'(bus.o_halted), 1);
      checkOutput("halt_valid", 32'(bus.o_upc_valid), 0);
      checkOutput("halt_busy", 32'(bus.o_busy), 0);
    end else begin
      if (len == 0) modelIllegal = 1'b1;
      checkOutput("back_upc", 32'(bus.o_upc), 1);
      checkOutput("back_valid", 32'(bus.o_upc_valid), 1);
      checkOutput("back_illegal", 32'(bus.o_illegal), 32'(modelIllegal));
    end
  endtask

  initial begin
    int opc;
    int pool[6] = '{4, 8, 12, 36, 52, 56};
    rst = 1'b1;
    bus.i_ir_opcode = '0;
    bus.i_z_flag = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick();
    doReset();

    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("idle_stall_upc", 32'(bus.o_upc), 0);
    checkOutput("idle_stall_busy", 32'(bus.o_busy), 0);
    applyStimulus(1'b0, 1'b0);

    startSeq();
    runInstr(4, 1'b0, 0);
    runInstr(52, 1'b0, 0);
    runInstr(52, 1'b1, 0);
    runInstr(8, 1'b0, 2);
    runInstr(5, 1'b0, 0);
    runInstr(12, 1'b0, 0);
    runInstr(36, 1'b1, 0);
    runInstr(56, 1'b0, 1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0) begin
        do opc = $urandom_range(63); while (opc == 57);
      end else begin
        opc = pool[$urandom_range(5)];
      end
      runInstr(opc, 1'($urandom_range(1)), 1);
    end

    runInstr(57, 1'b0, 1);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(1'b1, 1'($urandom_range(1)));
      tick();
      checkOutput("halt_hold_halted", 32'(bus.o_halted), 1);
      checkOutput("halt_hold_valid", 32'(bus.o_upc_valid), 0);
    end
    doReset();

    startSeq();
    bus.i_ir_opcode = 6'd4;
    for (int n = 0; n < 4; n++) tick();
    checkOutput("mid_upc_pre", 32'(bus.o_upc), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_upc", 32'(bus.o_upc), 0);
    checkOutput("mid_rst_valid", 32'(bus.o_upc_valid), 0);
    checkOutput("mid_rst_busy", 32'(bus.o_busy), 0);
    tick();
    checkOutput("mid_rst_idle", 32'(bus.o_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
